// File: rtl/bitonic_merge_pipe.sv
// Pipelined bitonic merger: LOG2_N registered compare-exchange stages over N = 2**LOG2_N key/label lanes.
// A single global enable advances or freezes every stage together, so no skid buffering is needed.
module bitonic_merge_pipe #(
    parameter int DATA_WIDTH  = 8,
    parameter int LABEL_WIDTH = 4,
    parameter int LOG2_N      = 4,
    parameter int SIGNED      = 0
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 x_valid,
    output logic                                 x_ready,
    input  logic                                 x_dir,
    input  logic [DATA_WIDTH*(2**LOG2_N)-1:0]    x,
    input  logic [LABEL_WIDTH*(2**LOG2_N)-1:0]   x_label,
    output logic                                 y_valid,
    input  logic                                 y_ready,
    output logic                                 y_dir,
    output logic [DATA_WIDTH*(2**LOG2_N)-1:0]    y,
    output logic [LABEL_WIDTH*(2**LOG2_N)-1:0]   y_label,
    output logic                                 busy
);
    localparam int N  = 2**LOG2_N;
    localparam int S  = LOG2_N;
    localparam int KW = DATA_WIDTH * N;
    localparam int LW = LABEL_WIDTH * N;

    logic [S-1:0]         v_q, v_d, dir_q, dir_d;
    logic [S-1:0][KW-1:0] key_in, key_d, key_q;
    logic [S-1:0][LW-1:0] lab_in, lab_d, lab_q;
    logic                 en;

    assign en = ~v_q[S-1] | y_ready;

    for (genvar s = 0; s < S; s++) begin : g_stage
        localparam int D = N >> (s + 1);

        if (s == 0) begin : g_src
            assign key_in[s] = x;
            assign lab_in[s] = x_label;
            assign dir_d[s]  = x_dir;
            assign v_d[s]    = x_valid;
        end else begin : g_src
            assign key_in[s] = key_q[s-1];
            assign lab_in[s] = lab_q[s-1];
            assign dir_d[s]  = dir_q[s-1];
            assign v_d[s]    = v_q[s-1];
        end

        // Only the lower lane of each j / j+D pair owns a comparator.
        for (genvar j = 0; j < N; j++) begin : g_lane
            if ((j / D) % 2 == 0) begin : g_ce
                logic [DATA_WIDTH-1:0]  a, b;
                logic [LABEL_WIDTH-1:0] la, lb;
                logic                   a_gt_b, b_gt_a, swap;

                assign a  = key_in[s][DATA_WIDTH*j +: DATA_WIDTH];
                assign b  = key_in[s][DATA_WIDTH*(j+D) +: DATA_WIDTH];
                assign la = lab_in[s][LABEL_WIDTH*j +: LABEL_WIDTH];
                assign lb = lab_in[s][LABEL_WIDTH*(j+D) +: LABEL_WIDTH];

                if (SIGNED != 0) begin : g_cmp
                    assign a_gt_b = $signed(a) > $signed(b);
                    assign b_gt_a = $signed(b) > $signed(a);
                end else begin : g_cmp
                    assign a_gt_b = a > b;
                    assign b_gt_a = b > a;
                end

                // Strict compares: equal keys never swap, keeping labels in lane order.
                assign swap = dir_d[s] ? a_gt_b : b_gt_a;

                assign key_d[s][DATA_WIDTH*j +: DATA_WIDTH]       = swap ? b : a;
                assign key_d[s][DATA_WIDTH*(j+D) +: DATA_WIDTH]   = swap ? a : b;
                assign lab_d[s][LABEL_WIDTH*j +: LABEL_WIDTH]     = swap ? lb : la;
                assign lab_d[s][LABEL_WIDTH*(j+D) +: LABEL_WIDTH] = swap ? la : lb;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            v_q   <= '0;
            dir_q <= '0;
            key_q <= '0;
            lab_q <= '0;
        end else if (en) begin
            v_q   <= v_d;
            dir_q <= dir_d;
            key_q <= key_d;
            lab_q <= lab_d;
        end
    end

    assign x_ready = en;
    assign y_valid = v_q[S-1];
    assign y_dir   = dir_q[S-1];
    assign y       = key_q[S-1];
    assign y_label = lab_q[S-1];
    assign busy    = |v_q;
endmodule

// File: tb/tb_bitonic_merge_pipe.sv
// Bench for bitonic_merge_pipe: directed 8-lane vectors, reset flush, backpressured and
// direction-alternating streams on 2-, 8- and 64-lane instances checked against a sort model.
module tb_bitonic_merge_pipe;
    logic clk, rst, x_dir, y_ready;

    logic          x_valid8, x_ready8, y_valid8, y_dir8, busy8;
    logic [63:0]   x8, y8;
    logic [31:0]   xl8, yl8;
    logic          x_ready8s, y_valid8s, y_dir8s, busy8s;
    logic [63:0]   y8s;
    logic [31:0]   yl8s;
    logic          x_valid1, x_ready1, y_valid1, y_dir1, busy1;
    logic [15:0]   x1, y1;
    logic [7:0]    xl1, yl1;
    logic          x_valid6, x_ready6, y_valid6, y_dir6, busy6;
    logic [511:0]  x6, y6, xl6, yl6;

    bitonic_merge_pipe #(.DATA_WIDTH(8), .LABEL_WIDTH(4), .LOG2_N(3), .SIGNED(0)) u8 (
        .clk(clk), .rst(rst), .x_valid(x_valid8), .x_ready(x_ready8), .x_dir(x_dir), .x(x8),
        .x_label(xl8), .y_valid(y_valid8), .y_ready(y_ready), .y_dir(y_dir8), .y(y8),
        .y_label(yl8), .busy(busy8));
    bitonic_merge_pipe #(.DATA_WIDTH(8), .LABEL_WIDTH(4), .LOG2_N(3), .SIGNED(1)) u8s (
        .clk(clk), .rst(rst), .x_valid(x_valid8), .x_ready(x_ready8s), .x_dir(x_dir), .x(x8),
        .x_label(xl8), .y_valid(y_valid8s), .y_ready(y_ready), .y_dir(y_dir8s), .y(y8s),
        .y_label(yl8s), .busy(busy8s));
    bitonic_merge_pipe #(.DATA_WIDTH(8), .LABEL_WIDTH(4), .LOG2_N(1), .SIGNED(0)) u1 (
        .clk(clk), .rst(rst), .x_valid(x_valid1), .x_ready(x_ready1), .x_dir(x_dir), .x(x1),
        .x_label(xl1), .y_valid(y_valid1), .y_ready(y_ready), .y_dir(y_dir1), .y(y1),
        .y_label(yl1), .busy(busy1));
    bitonic_merge_pipe #(.DATA_WIDTH(8), .LABEL_WIDTH(8), .LOG2_N(6), .SIGNED(0)) u6 (
        .clk(clk), .rst(rst), .x_valid(x_valid6), .x_ready(x_ready6), .x_dir(x_dir), .x(x6),
        .x_label(xl6), .y_valid(y_valid6), .y_ready(y_ready), .y_dir(y_dir6), .y(y6),
        .y_label(yl6), .busy(busy6));

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int pass_cnt = 0, total_cnt = 0;

    task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    typedef struct {
        logic [63:0] x;  logic [31:0] xl; logic dir;
        logic [63:0] y;  logic [31:0] yl;
        logic        chk_s;
        logic [63:0] ys; logic [31:0] ysl;
    } vec_t;
    vec_t tbl[6];

    typedef struct {
        logic [511:0] k; logic [511:0] l; logic d; int t;
    } exp_t;

    function automatic logic [63:0] k8(input int a0, a1, a2, a3, a4, a5, a6, a7);
        return {a7[7:0], a6[7:0], a5[7:0], a4[7:0], a3[7:0], a2[7:0], a1[7:0], a0[7:0]};
    endfunction
    function automatic logic [31:0] l8(input int a0, a1, a2, a3, a4, a5, a6, a7);
        return {a7[3:0], a6[3:0], a5[3:0], a4[3:0], a3[3:0], a2[3:0], a1[3:0], a0[3:0]};
    endfunction

    // Reference model: plain bubble sort of key/label pairs, independent of the network.
    int wk[64], wl[64];
    task automatic wsort(input int lo, input int hi, input bit asc);
        for (int a = lo; a < hi; a++)
            for (int b = lo; b < hi - 1 - (a - lo); b++)
                if (asc ? (wk[b] > wk[b+1]) : (wk[b] < wk[b+1])) begin
                    int tk, tl;
                    tk = wk[b]; wk[b] = wk[b+1]; wk[b+1] = tk;
                    tl = wl[b]; wl[b] = wl[b+1]; wl[b+1] = tl;
                end
    endtask

    // Distinct keys make the expected key/label placement unique.
    task automatic build(input int n, input bit d, input int lw,
                         output logic [511:0] pk, output logic [511:0] pl,
                         output logic [511:0] ek, output logic [511:0] el);
        int pool[256];
        int t;
        for (int i = 0; i < 256; i++) pool[i] = i;
        for (int i = 0; i < n; i++) begin
            int j;
            j = $urandom_range(255, i);
            t = pool[i]; pool[i] = pool[j]; pool[j] = t;
            wk[i] = pool[i];
            wl[i] = i;
        end
        wsort(0, n/2, d);
        wsort(n/2, n, !d);
        pk = '0; pl = '0; ek = '0; el = '0;
        for (int i = 0; i < n; i++) begin
            wl[i] = i;
            t = wk[i];
            pk[8*i +: 8] = t[7:0];
            t = wl[i];
            for (int b = 0; b < lw; b++) pl[lw*i + b] = t[b];
        end
        wsort(0, n, d);
        for (int i = 0; i < n; i++) begin
            t = wk[i];
            ek[8*i +: 8] = t[7:0];
            t = wl[i];
            for (int b = 0; b < lw; b++) el[lw*i + b] = t[b];
        end
    endtask

    task automatic drive(input int which, input bit v, input logic [511:0] pk,
                         input logic [511:0] pl, input bit d);
        x_dir = d;
        x_valid8 = 1'b0; x_valid1 = 1'b0; x_valid6 = 1'b0;
        case (which)
            8:       begin x_valid8 = v; x8 = pk[63:0]; xl8 = pl[31:0]; end
            1:       begin x_valid1 = v; x1 = pk[15:0]; xl1 = pl[7:0]; end
            default: begin x_valid6 = v; x6 = pk;       xl6 = pl;       end
        endcase
    endtask

    task automatic sample(input int which, output logic xr, output logic yv,
                          output logic [511:0] yk, output logic [511:0] yl, output logic yd);
        yk = '0; yl = '0;
        case (which)
            8:       begin xr = x_ready8; yv = y_valid8; yk[63:0] = y8; yl[31:0] = yl8; yd = y_dir8; end
            1:       begin xr = x_ready1; yv = y_valid1; yk[15:0] = y1; yl[7:0] = yl1; yd = y_dir1; end
            default: begin xr = x_ready6; yv = y_valid6; yk = y6; yl = yl6; yd = y_dir6; end
        endcase
    endtask

    // Called on a falling edge; every handshake decision is taken 1 time unit later.
    task automatic stream(input int which, input int nvec, input bit bp, input bit alt);
        exp_t q[$];
        exp_t e;
        int n, lw, lat, sent, got, cyc, hold_left, extra;
        bit have, d, stall_prev, prev_d;
        logic xr, yv, yd;
        logic [511:0] pk, pl, ek, el, yk, yl, prev_k, prev_l;
        n   = (which == 8) ? 8 : (which == 1) ? 2 : 64;
        lw  = (which == 6) ? 8 : 4;
        lat = (which == 8) ? 3 : (which == 1) ? 1 : 6;
        sent = 0; got = 0; cyc = 0; hold_left = 0; have = 0; d = 0;
        stall_prev = 0; prev_d = 0; prev_k = '0; prev_l = '0;
        y_ready = 1'b1;
        while (got < nvec && cyc < 3000) begin
            if (bp) begin
                if (hold_left == 0) begin
                    y_ready = ~y_ready;
                    hold_left = $urandom_range(3, 1);
                end
                hold_left--;
            end else y_ready = 1'b1;
            if (!have && sent < nvec) begin
                d = alt ? (sent % 2 == 0) : 1'($urandom_range(1, 0));
                build(n, d, lw, pk, pl, ek, el);
                have = 1;
            end
            drive(which, have, pk, pl, d);
            #1;
            sample(which, xr, yv, yk, yl, yd);
            if (stall_prev) begin
                chk($sformatf("stall_hold_valid n=%0d", n), yv, 1);
                chk($sformatf("stall_hold_keys n=%0d", n), yk, prev_k);
                chk($sformatf("stall_hold_labels n=%0d", n), yl, prev_l);
                chk($sformatf("stall_hold_dir n=%0d", n), yd, prev_d);
            end
            if (yv && y_ready) begin
                if (q.size() == 0) chk($sformatf("spurious_output n=%0d", n), 1, 0);
                else begin
                    e = q.pop_front();
                    chk($sformatf("stream_keys n=%0d #%0d", n, got), yk, e.k);
                    chk($sformatf("stream_labels n=%0d #%0d", n, got), yl, e.l);
                    chk($sformatf("stream_dir n=%0d #%0d", n, got), yd, e.d);
                    if (!bp) chk($sformatf("stream_latency n=%0d #%0d", n, got), cyc - e.t, lat);
                end
                got++;
            end
            stall_prev = yv && !y_ready;
            prev_k = yk; prev_l = yl; prev_d = yd;
            if (alt && !bp && sent < nvec) chk($sformatf("full_rate_x_ready n=%0d", n), xr, 1);
            if (have && xr) begin
                e.k = ek; e.l = el; e.d = d; e.t = cyc;
                q.push_back(e);
                sent++;
                have = 0;
            end
            @(negedge clk);
            cyc++;
        end
        drive(which, 0, '0, '0, 0);
        y_ready = 1'b1;
        chk($sformatf("stream_all_received n=%0d", n), got, nvec);
        extra = 0;
        for (int i = 0; i < lat + 2; i++) begin
            #1;
            sample(which, xr, yv, yk, yl, yd);
            if (yv) extra++;
            @(negedge clk);
        end
        chk($sformatf("stream_no_duplicate n=%0d", n), extra, 0);
    endtask

    initial begin
        int seen;
        clk = 0; rst = 0; x_dir = 0; y_ready = 1;
        x_valid8 = 0; x8 = '0; xl8 = '0;
        x_valid1 = 0; x1 = '0; xl1 = '0;
        x_valid6 = 0; x6 = '0; xl6 = '0;

        tbl[0] = '{k8(1,4,6,9,8,5,3,2), l8(0,1,2,3,4,5,6,7), 1'b1,
                   k8(1,2,3,4,5,6,8,9), l8(0,7,6,1,5,2,4,3), 1'b1,
                   k8(1,2,3,4,5,6,8,9), l8(0,7,6,1,5,2,4,3)};
        // Unsigned view of this vector is not bitonic; expected values traced through the network by hand.
        tbl[1] = '{k8(7,2,-1,-8,-5,0,3,6), l8(0,1,2,3,4,5,6,7), 1'b0,
                   k8(-1,-8,-5,2,7,6,3,0), l8(2,3,4,1,0,7,6,5), 1'b1,
                   k8(7,6,3,2,0,-1,-5,-8), l8(0,7,6,1,5,2,4,3)};
        tbl[2] = '{k8(5,5,5,5,5,5,5,5), l8(0,1,2,3,4,5,6,7), 1'b1,
                   k8(5,5,5,5,5,5,5,5), l8(0,1,2,3,4,5,6,7), 1'b1,
                   k8(5,5,5,5,5,5,5,5), l8(0,1,2,3,4,5,6,7)};
        tbl[3] = '{k8(5,5,5,5,5,5,5,5), l8(0,1,2,3,4,5,6,7), 1'b0,
                   k8(5,5,5,5,5,5,5,5), l8(0,1,2,3,4,5,6,7), 1'b1,
                   k8(5,5,5,5,5,5,5,5), l8(0,1,2,3,4,5,6,7)};
        tbl[4] = '{k8(9,6,4,1,2,3,5,8), l8(0,1,2,3,4,5,6,7), 1'b0,
                   k8(9,8,6,5,4,3,2,1), l8(0,7,1,6,2,5,4,3), 1'b1,
                   k8(9,8,6,5,4,3,2,1), l8(0,7,1,6,2,5,4,3)};
        tbl[5] = '{k8(16,128,192,255,240,144,32,0), l8(0,1,2,3,4,5,6,7), 1'b1,
                   k8(0,16,32,128,144,192,240,255), l8(7,0,6,1,5,2,4,3), 1'b0,
                   64'h0, 32'h0};

        // Reset state
        repeat (3) @(negedge clk);
        #1;
        chk("reset_y_valid", y_valid8, 0);
        chk("reset_busy", busy8, 0);
        chk("reset_x_ready", x_ready8, 1);
        chk("reset_y", y8, 0);
        chk("reset_y_label", yl8, 0);
        chk("reset_y_dir", y_dir8, 0);
        @(negedge clk);
        rst = 1;
        @(negedge clk);

        // Directed table on the 8-lane pair (unsigned and signed share the inputs)
        for (int i = 0; i < 6; i++) begin
            x8 = tbl[i].x; xl8 = tbl[i].xl; x_dir = tbl[i].dir; x_valid8 = 1; y_ready = 1;
            @(negedge clk);
            x_valid8 = 0;
            @(negedge clk);
            #1;
            if (i == 0) chk("latency_not_early", y_valid8, 0);
            @(negedge clk);
            #1;
            chk($sformatf("vec%0d_y_valid", i), y_valid8, 1);
            chk($sformatf("vec%0d_y", i), y8, tbl[i].y);
            chk($sformatf("vec%0d_y_label", i), yl8, tbl[i].yl);
            chk($sformatf("vec%0d_y_dir", i), y_dir8, tbl[i].dir);
            if (tbl[i].chk_s) begin
                chk($sformatf("vec%0d_signed_y", i), y8s, tbl[i].ys);
                chk($sformatf("vec%0d_signed_y_label", i), yl8s, tbl[i].ysl);
            end
            @(negedge clk);
        end

        // Reset mid-stream with three vectors in flight
        y_ready = 0;
        for (int i = 0; i < 3; i++) begin
            x8 = tbl[i].x; xl8 = tbl[i].xl; x_dir = tbl[i].dir; x_valid8 = 1;
            @(negedge clk);
        end
        x_valid8 = 0;
        #1;
        chk("inflight_busy_before_reset", busy8, 1);
        rst = 0;
        #1;
        chk("midreset_y_valid", y_valid8, 0);
        chk("midreset_busy", busy8, 0);
        chk("midreset_x_ready", x_ready8, 1);
        chk("midreset_y", y8, 0);
        @(negedge clk);
        rst = 1;
        y_ready = 1;
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            #1;
            if (y_valid8 || busy8) seen++;
        end
        chk("no_stale_after_reset", seen, 0);
        @(negedge clk);

        stream(8, 20, 1'b1, 1'b0);
        stream(8, 16, 1'b0, 1'b1);
        stream(1, 12, 1'b0, 1'b1);
        stream(6, 12, 1'b0, 1'b1);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
